// File: rtl/cache_axi_bridge.sv
// cache_axi_bridge: turns the cache miss-handling request ports into AXI4
// master transactions on a 32-bit bus. Reads and writes each run in their own
// engine with one transaction outstanding. A read to a line that has a write
// in flight, or that is being accepted this cycle, is held off.
//
// Ports
//   clk, resetn                 clock, synchronous active-low reset
//   rd_req/rd_type/rd_addr      cache read request        -> rd_rdy
//   ret_valid/ret_last/ret_data returned read words (combinational from R)
//   wr_req/wr_type/wr_addr      cache write request       -> wr_rdy
//   wr_wstrb/wr_data            write byte mask / line data
//   ar*/r*                      AXI4 read address and read data channels
//   aw*/w*/b*                   AXI4 write address, write data, response
module cache_axi_bridge #(
  parameter logic [3:0] RD_ID = 4'd0,
  parameter logic [3:0] WR_ID = 4'd1
) (
  input  logic         clk,
  input  logic         resetn,
  // cache read side
  input  logic         rd_req,
  input  logic [2:0]   rd_type,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic         ret_last,
  output logic [31:0]  ret_data,
  // cache write side
  input  logic         wr_req,
  input  logic [2:0]   wr_type,
  input  logic [31:0]  wr_addr,
  input  logic [3:0]   wr_wstrb,
  input  logic [127:0] wr_data,
  output logic         wr_rdy,
  // AXI AR
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arvalid,
  input  logic         arready,
  // AXI R
  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready,
  // AXI AW
  output logic [3:0]   awid,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic         awvalid,
  input  logic         awready,
  // AXI W
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  // AXI B
  input  logic [3:0]   bid,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready
);

  localparam logic [2:0] TYPE_LINE  = 3'b100;
  localparam logic [7:0] LEN_LINE   = 8'd3;
  localparam logic [7:0] LEN_SINGLE = 8'd0;
  localparam logic [2:0] SIZE_WORD  = 3'd2;
  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} wr_state_t;

  rd_state_t      r_rd_state;
  rd_state_t      w_rd_state_nxt;
  logic [31:0]    r_rd_addr;
  logic [2:0]     r_rd_type;

  wr_state_t      r_wr_state;
  wr_state_t      w_wr_state_nxt;
  logic [31:0]    r_wr_addr;
  logic [2:0]     r_wr_type;
  logic [3:0]     r_wr_wstrb;
  logic [127:0]   r_wr_data;
  logic [1:0]     r_beat;

  logic           w_wr_accept;
  logic           w_hazard;
  logic           w_rd_accept;
  logic           w_rd_line;
  logic           w_wr_line;
  logic           w_unused;

  // Response IDs and codes carry no information for a single-ID master.
  assign w_unused = ^{rid, rresp, bid, bresp};

  assign w_wr_accept = wr_req & (r_wr_state == W_IDLE);

  // Same-line RAW block: compare the read line against an in-flight write or
  // against a write being accepted in this very cycle.
  assign w_hazard = ((r_wr_state != W_IDLE) && (r_wr_addr[31:4] == rd_addr[31:4])) ||
                    (w_wr_accept && (wr_addr[31:4] == rd_addr[31:4]));

  assign w_rd_accept = rd_req & (r_rd_state == R_IDLE) & ~w_hazard;

  // ---------------- read engine ----------------

  // Read state register
  always_ff @(posedge clk) begin
    if (!resetn) r_rd_state <= R_IDLE;
    else         r_rd_state <= w_rd_state_nxt;
  end

  // Read next state and handshake outputs
  always_comb begin
    w_rd_state_nxt = r_rd_state;
    rd_rdy         = 1'b0;
    arvalid        = 1'b0;
    rready         = 1'b0;
    case (r_rd_state)
      R_IDLE: begin
        rd_rdy = ~w_hazard;
        if (w_rd_accept) w_rd_state_nxt = R_AR;
      end
      R_AR: begin
        arvalid = 1'b1;
        if (arready) w_rd_state_nxt = R_DATA;
      end
      R_DATA: begin
        rready = 1'b1;
        if (rvalid && rlast) w_rd_state_nxt = R_IDLE;
      end
      default: w_rd_state_nxt = R_IDLE;
    endcase
  end

  // Read request capture
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rd_addr <= 32'd0;
      r_rd_type <= 3'd0;
    end else if (w_rd_accept) begin
      r_rd_addr <= rd_addr;
      r_rd_type <= rd_type;
    end
  end

  assign w_rd_line = (r_rd_type == TYPE_LINE);
  assign arid      = RD_ID;
  assign araddr    = r_rd_addr;
  assign arlen     = w_rd_line ? LEN_LINE : LEN_SINGLE;
  assign arsize    = w_rd_line ? SIZE_WORD : {1'b0, r_rd_type[1:0]};
  assign arburst   = BURST_INCR;

  // Returned data passes straight through; the cache never stalls it.
  assign ret_valid = rready & rvalid;
  assign ret_last  = rready & rvalid & rlast;
  assign ret_data  = rdata;

  // ---------------- write engine ----------------

  // Write state register
  always_ff @(posedge clk) begin
    if (!resetn) r_wr_state <= W_IDLE;
    else         r_wr_state <= w_wr_state_nxt;
  end

  // Write next state and handshake outputs
  always_comb begin
    w_wr_state_nxt = r_wr_state;
    wr_rdy         = 1'b0;
    awvalid        = 1'b0;
    wvalid         = 1'b0;
    wlast          = 1'b0;
    bready         = 1'b0;
    case (r_wr_state)
      W_IDLE: begin
        wr_rdy = 1'b1;
        if (wr_req) w_wr_state_nxt = W_AW;
      end
      W_AW: begin
        awvalid = 1'b1;
        if (awready) w_wr_state_nxt = W_DATA;
      end
      W_DATA: begin
        wvalid = 1'b1;
        wlast  = (r_beat == awlen[1:0]);
        if (wready && wlast) w_wr_state_nxt = W_RESP;
      end
      W_RESP: begin
        bready = 1'b1;
        if (bvalid) w_wr_state_nxt = W_IDLE;
      end
      default: w_wr_state_nxt = W_IDLE;
    endcase
  end

  // Write request capture and beat counter
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_addr  <= 32'd0;
      r_wr_type  <= 3'd0;
      r_wr_wstrb <= 4'd0;
      r_wr_data  <= 128'd0;
      r_beat     <= 2'd0;
    end else if (w_wr_accept) begin
      r_wr_addr  <= wr_addr;
      r_wr_type  <= wr_type;
      r_wr_wstrb <= wr_wstrb;
      r_wr_data  <= wr_data;
      r_beat     <= 2'd0;
    end else if (wvalid && wready) begin
      r_beat     <= r_beat + 2'd1;
    end
  end

  assign w_wr_line = (r_wr_type == TYPE_LINE);
  assign awid      = WR_ID;
  assign awaddr    = r_wr_addr;
  assign awlen     = w_wr_line ? LEN_LINE : LEN_SINGLE;
  assign awsize    = w_wr_line ? SIZE_WORD : {1'b0, r_wr_type[1:0]};
  assign awburst   = BURST_INCR;
  assign wdata     = r_wr_data[{r_beat, 5'd0} +: 32];
  assign wstrb     = w_wr_line ? 4'hF : r_wr_wstrb;

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Self-checking bench for cache_axi_bridge. The bench plays both the cache and
// an AXI slave; expected bursts come from the request type rules and a queue
// of words the write is supposed to emit in order.
module tb_cache_axi_bridge;

  logic         clk;
  logic         resetn;
  logic         rd_req;
  logic [2:0]   rd_type;
  logic [31:0]  rd_addr;
  logic         rd_rdy;
  logic         ret_valid;
  logic         ret_last;
  logic [31:0]  ret_data;
  logic         wr_req;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [3:0]   wr_wstrb;
  logic [127:0] wr_data;
  logic         wr_rdy;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready;
  logic [3:0]   rid;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;
  logic [3:0]   awid;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;
  logic [3:0]   bid;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;

  int n_cmp = 0;
  int n_err = 0;

  cache_axi_bridge dut (
    .clk(clk), .resetn(resetn),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Move to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected AXI length/size from the request type.
  function automatic logic [7:0] exp_len(input logic [2:0] t);
    return (t == 3'b100) ? 8'd3 : 8'd0;
  endfunction

  function automatic logic [2:0] exp_size(input logic [2:0] t);
    return (t == 3'b100) ? 3'd2 : {1'b0, t[1:0]};
  endfunction

  function automatic logic [2:0] rnd_type();
    logic [2:0] tt [4];
    tt[0] = 3'b000; tt[1] = 3'b001; tt[2] = 3'b010; tt[3] = 3'b100;
    return tt[$urandom_range(3, 0)];
  endfunction

  // One complete read as cache + slave. rnd selects random data, else base+i.
  task automatic run_read(input logic [31:0] addr, input logic [2:0] typ, input int ar_delay,
                          input int max_gap, input bit rnd, input logic [31:0] base);
    int cnt;
    int nb;
    logic [31:0] word;
    nb = int'(exp_len(typ)) + 1;
    rd_req = 1'b1; rd_addr = addr; rd_type = typ;
    #1;
    cnt = 0;
    while (!rd_rdy && cnt < 50) begin tick(); cnt++; end
    n_cmp++; if (rd_rdy !== 1'b1) begin n_err++; $display("FAIL rd_accept_wait got %b exp 1", rd_rdy); end
    tick();
    rd_req = 1'b0; rd_addr = $urandom; rd_type = 3'($urandom);
    #1;
    n_cmp++; if (arvalid !== 1'b1) begin n_err++; $display("FAIL arvalid got %b exp 1", arvalid); end
    n_cmp++; if (araddr !== addr) begin n_err++; $display("FAIL araddr got %h exp %h", araddr, addr); end
    n_cmp++; if (arlen !== exp_len(typ)) begin n_err++; $display("FAIL arlen got %0d exp %0d", arlen, exp_len(typ)); end
    n_cmp++; if (arsize !== exp_size(typ)) begin n_err++; $display("FAIL arsize got %0d exp %0d", arsize, exp_size(typ)); end
    n_cmp++; if (arburst !== 2'b01 || arid !== 4'd0) begin n_err++; $display("FAIL arburst_arid got %b/%0d exp 01/0", arburst, arid); end
    repeat (ar_delay) tick();
    n_cmp++; if (arvalid !== 1'b1 || araddr !== addr) begin n_err++; $display("FAIL ar_stable got %b/%h exp 1/%h", arvalid, araddr, addr); end
    arready = 1'b1;
    tick();
    arready = 1'b0;
    #1;
    n_cmp++; if (arvalid !== 1'b0 || rready !== 1'b1) begin n_err++; $display("FAIL ar_done got arvalid %b rready %b exp 0/1", arvalid, rready); end
    for (int i = 0; i < nb; i++) begin
      repeat ($urandom_range(max_gap, 0)) begin
        rvalid = 1'b0; rdata = $urandom; rlast = 1'b1;
        #1;
        n_cmp++; if (ret_valid !== 1'b0 || ret_last !== 1'b0) begin n_err++; $display("FAIL ret_gap got %b/%b exp 0/0", ret_valid, ret_last); end
        tick();
      end
      word = rnd ? 32'($urandom) : base + 32'(i);
      rvalid = 1'b1; rdata = word; rlast = (i == nb - 1);
      rid = 4'($urandom); rresp = 2'($urandom);
      #1;
      n_cmp++; if (ret_valid !== 1'b1 || ret_data !== word) begin n_err++; $display("FAIL ret_beat%0d got %b/%h exp 1/%h", i, ret_valid, ret_data, word); end
      n_cmp++; if (ret_last !== (i == nb - 1)) begin n_err++; $display("FAIL ret_last%0d got %b exp %b", i, ret_last, (i == nb - 1)); end
      tick();
    end
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    n_cmp++; if (rd_rdy !== 1'b1 || rready !== 1'b0) begin n_err++; $display("FAIL rd_done got rd_rdy %b rready %b exp 1/0", rd_rdy, rready); end
  endtask

  // One complete write. pat gives wready per W-phase cycle for pat_len cycles, 1 after.
  task automatic run_write(input logic [31:0] addr, input logic [2:0] typ, input logic [3:0] strb,
                           input logic [127:0] data, input int aw_delay,
                           input logic [15:0] pat, input int pat_len, input int b_delay);
    logic [31:0] exp_q[$];
    logic [3:0] estrb;
    int cyc;
    int hs;
    estrb = (typ == 3'b100) ? 4'hF : strb;
    if (typ == 3'b100) for (int i = 0; i < 4; i++) exp_q.push_back(data[32*i +: 32]);
    else exp_q.push_back(data[31:0]);
    #1;
    n_cmp++; if (wr_rdy !== 1'b1) begin n_err++; $display("FAIL wr_rdy_idle got %b exp 1", wr_rdy); end
    wr_req = 1'b1; wr_addr = addr; wr_type = typ; wr_wstrb = strb; wr_data = data;
    tick();
    wr_req = 1'b0; wr_addr = $urandom; wr_type = 3'($urandom); wr_wstrb = 4'($urandom);
    wr_data = {$urandom, $urandom, $urandom, $urandom};
    #1;
    n_cmp++; if (wr_rdy !== 1'b0 || awvalid !== 1'b1) begin n_err++; $display("FAIL aw_start got wr_rdy %b awvalid %b exp 0/1", wr_rdy, awvalid); end
    n_cmp++; if (awaddr !== addr) begin n_err++; $display("FAIL awaddr got %h exp %h", awaddr, addr); end
    n_cmp++; if (awlen !== exp_len(typ)) begin n_err++; $display("FAIL awlen got %0d exp %0d", awlen, exp_len(typ)); end
    n_cmp++; if (awsize !== exp_size(typ)) begin n_err++; $display("FAIL awsize got %0d exp %0d", awsize, exp_size(typ)); end
    n_cmp++; if (awburst !== 2'b01 || awid !== 4'd1) begin n_err++; $display("FAIL awburst_awid got %b/%0d exp 01/1", awburst, awid); end
    repeat (aw_delay) tick();
    awready = 1'b1;
    tick();
    awready = 1'b0;
    cyc = 0; hs = 0;
    while (exp_q.size() > 0 && cyc < 64) begin
      wready = (cyc < pat_len) ? pat[cyc] : 1'b1;
      #1;
      n_cmp++; if (wvalid !== 1'b1 || wdata !== exp_q[0]) begin n_err++; $display("FAIL wbeat%0d got %b/%h exp 1/%h", hs, wvalid, wdata, exp_q[0]); end
      n_cmp++; if (wstrb !== estrb || wlast !== (exp_q.size() == 1)) begin n_err++; $display("FAIL wstrb_wlast%0d got %h/%b exp %h/%b", hs, wstrb, wlast, estrb, (exp_q.size() == 1)); end
      n_cmp++; if (wr_rdy !== 1'b0) begin n_err++; $display("FAIL wr_rdy_busy got %b exp 0", wr_rdy); end
      if (wready) begin void'(exp_q.pop_front()); hs++; end
      tick();
      cyc++;
    end
    wready = 1'b0;
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL w_budget got %0d beats left exp 0", exp_q.size()); end
    #1;
    n_cmp++; if (wvalid !== 1'b0 || bready !== 1'b1) begin n_err++; $display("FAIL w_done got wvalid %b bready %b exp 0/1", wvalid, bready); end
    repeat (b_delay) begin
      tick();
      n_cmp++; if (wr_rdy !== 1'b0 || wvalid !== 1'b0) begin n_err++; $display("FAIL b_wait got wr_rdy %b wvalid %b exp 0/0", wr_rdy, wvalid); end
    end
    bvalid = 1'b1; bid = 4'($urandom); bresp = 2'($urandom);
    tick();
    bvalid = 1'b0;
    #1;
    n_cmp++; if (wr_rdy !== 1'b1 || bready !== 1'b0) begin n_err++; $display("FAIL b_done got wr_rdy %b bready %b exp 1/0", wr_rdy, bready); end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick(); tick();
    n_cmp++; if ({arvalid, rready, awvalid, wvalid, wlast, bready, ret_valid} !== 7'b0) begin n_err++; $display("FAIL reset_valids got %b exp 0", {arvalid, rready, awvalid, wvalid, wlast, bready, ret_valid}); end
    n_cmp++; if (rd_rdy !== 1'b1 || wr_rdy !== 1'b1) begin n_err++; $display("FAIL reset_rdy got %b/%b exp 1/1", rd_rdy, wr_rdy); end
    n_cmp++; if (araddr !== 32'd0 || awaddr !== 32'd0 || wdata !== 32'd0 || wstrb !== 4'd0) begin n_err++; $display("FAIL reset_regs got %h/%h/%h/%h exp 0", araddr, awaddr, wdata, wstrb); end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_line_read();
    run_read(32'h1C000040, 3'b100, 2, 0, 1'b0, 32'hA0);
  endtask

  task automatic test_line_write();
    run_write(32'h00001230, 3'b100, 4'h0, 128'h33333333_22222222_11111111_00000000, 1, 16'h0, 0, 2);
  endtask

  task automatic test_byte_write();
    run_write(32'hBFAF8002, 3'b000, 4'b0100, 128'hDEADBEEF, 0, 16'h0, 0, 0);
  endtask

  task automatic test_w_backpressure();
    run_write(32'h00004560, 3'b100, 4'h0, 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000, 0, 16'b1010101, 7, 1);
  endtask

  task automatic test_raw_hazard();
    // line write to 0x1000 held in the response phase
    wr_req = 1'b1; wr_addr = 32'h1000; wr_type = 3'b100; wr_wstrb = 4'h0;
    wr_data = 128'h4_3_2_1;
    tick();
    wr_req = 1'b0;
    awready = 1'b1; tick(); awready = 1'b0;
    wready = 1'b1; repeat (4) tick(); wready = 1'b0;
    #1;
    n_cmp++; if (bready !== 1'b1) begin n_err++; $display("FAIL raw_bready got %b exp 1", bready); end
    rd_req = 1'b1; rd_addr = 32'h1008; rd_type = 3'b010;
    repeat (3) begin
      #1;
      n_cmp++; if (rd_rdy !== 1'b0 || arvalid !== 1'b0) begin n_err++; $display("FAIL raw_block got rd_rdy %b arvalid %b exp 0/0", rd_rdy, arvalid); end
      tick();
    end
    rd_req = 1'b0;
    // a different line goes through while the write is still pending
    run_read(32'h2000, 3'b010, 0, 0, 1'b1, 32'h0);
    rd_req = 1'b1; rd_addr = 32'h1008; rd_type = 3'b010;
    #1;
    n_cmp++; if (rd_rdy !== 1'b0) begin n_err++; $display("FAIL raw_block2 got %b exp 0", rd_rdy); end
    bvalid = 1'b1; tick(); bvalid = 1'b0;
    #1;
    n_cmp++; if (rd_rdy !== 1'b1 || wr_rdy !== 1'b1) begin n_err++; $display("FAIL raw_release got %b/%b exp 1/1", rd_rdy, wr_rdy); end
    run_read(32'h1008, 3'b010, 0, 1, 1'b1, 32'h0);
    // same-line write accepted in the same cycle as the read attempt
    wr_req = 1'b1; wr_addr = 32'h3000; wr_type = 3'b010; wr_wstrb = 4'hF; wr_data = 128'h55;
    rd_req = 1'b1; rd_addr = 32'h300C; rd_type = 3'b010;
    #1;
    n_cmp++; if (rd_rdy !== 1'b0 || wr_rdy !== 1'b1) begin n_err++; $display("FAIL raw_same_cycle got %b/%b exp 0/1", rd_rdy, wr_rdy); end
    tick();
    wr_req = 1'b0; rd_req = 1'b0;
    #1;
    n_cmp++; if (arvalid !== 1'b0 || awvalid !== 1'b1) begin n_err++; $display("FAIL raw_same_after got %b/%b exp 0/1", arvalid, awvalid); end
    awready = 1'b1; tick(); awready = 1'b0;
    wready = 1'b1; tick(); wready = 1'b0;
    bvalid = 1'b1; tick(); bvalid = 1'b0;
    run_read(32'h300C, 3'b010, 0, 0, 1'b1, 32'h0);
  endtask

  task automatic test_concurrent();
    wr_req = 1'b1; wr_addr = 32'h4000; wr_type = 3'b010; wr_wstrb = 4'hF; wr_data = 128'h77;
    rd_req = 1'b1; rd_addr = 32'h5000; rd_type = 3'b010;
    #1;
    n_cmp++; if (rd_rdy !== 1'b1 || wr_rdy !== 1'b1) begin n_err++; $display("FAIL conc_rdy got %b/%b exp 1/1", rd_rdy, wr_rdy); end
    tick();
    wr_req = 1'b0; rd_req = 1'b0;
    #1;
    n_cmp++; if (arvalid !== 1'b1 || awvalid !== 1'b1 || araddr !== 32'h5000 || awaddr !== 32'h4000) begin n_err++; $display("FAIL conc_addr got %b/%b %h/%h exp 1/1 5000/4000", arvalid, awvalid, araddr, awaddr); end
    arready = 1'b1; awready = 1'b1; tick(); arready = 1'b0; awready = 1'b0;
    rvalid = 1'b1; rdata = 32'h99; rlast = 1'b1; wready = 1'b1;
    #1;
    n_cmp++; if (ret_valid !== 1'b1 || ret_data !== 32'h99 || wvalid !== 1'b1 || wdata !== 32'h77 || wlast !== 1'b1) begin n_err++; $display("FAIL conc_data got %b %h %b %h %b exp 1 99 1 77 1", ret_valid, ret_data, wvalid, wdata, wlast); end
    tick();
    rvalid = 1'b0; rlast = 1'b0; wready = 1'b0;
    bvalid = 1'b1; tick(); bvalid = 1'b0;
    #1;
    n_cmp++; if (rd_rdy !== 1'b1 || wr_rdy !== 1'b1) begin n_err++; $display("FAIL conc_done got %b/%b exp 1/1", rd_rdy, wr_rdy); end
  endtask

  task automatic test_reset_mid_read();
    rd_req = 1'b1; rd_addr = 32'h0000_0800; rd_type = 3'b100;
    tick();
    rd_req = 1'b0;
    arready = 1'b1; tick(); arready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rvalid = 1'b1; rdata = 32'hB0 + 32'(i); rlast = 1'b0; tick();
    end
    rdata = 32'hB2;
    resetn = 1'b0;
    tick();
    n_cmp++; if (arvalid !== 1'b0 || rready !== 1'b0 || ret_valid !== 1'b0 || rd_rdy !== 1'b1) begin n_err++; $display("FAIL reset_mid got %b %b %b %b exp 0 0 0 1", arvalid, rready, ret_valid, rd_rdy); end
    rvalid = 1'b0;
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [2:0] t;
    for (int n = 0; n < 30; n++) begin
      a = $urandom; t = rnd_type();
      if ($urandom_range(1, 0) == 1)
        run_read(a, t, $urandom_range(3, 0), 2, 1'b1, 32'h0);
      else
        run_write(a, t, 4'($urandom), {$urandom, $urandom, $urandom, $urandom},
                  $urandom_range(3, 0), 16'($urandom), $urandom_range(8, 0), $urandom_range(3, 0));
      tick();
    end
  endtask

  initial begin
    resetn = 1'b0;
    rd_req = 1'b0; rd_type = 3'd0; rd_addr = 32'd0;
    wr_req = 1'b0; wr_type = 3'd0; wr_addr = 32'd0; wr_wstrb = 4'd0; wr_data = 128'd0;
    arready = 1'b0; rid = 4'd0; rdata = 32'd0; rresp = 2'd0; rlast = 1'b0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bid = 4'd0; bresp = 2'd0; bvalid = 1'b0;
    test_reset();
    test_line_read();
    test_line_write();
    test_byte_write();
    test_w_backpressure();
    test_raw_hazard();
    test_concurrent();
    test_reset_mid_read();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cache_axi_bridge.md
Name: cache_axi_bridge

Overview:
- Downstream neighbour of the cache's miss-handling interface. Converts the cache-side request ports into AXI4 master transactions on a 32-bit bus:
  - rd_*/ret_* become the AR and R channels.
  - wr_* become the AW, W and B channels.
- Independent read and write engines, one outstanding transaction each, with a same-line read-after-write hazard block.

Parameters:
RD_ID, 4'd0, constant driven on arid
WR_ID, 4'd1, constant driven on awid

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
rd_req  in  1  cache read request; held until rd_rdy
rd_type  in  3  000 byte, 001 half, 010 word, 100 line
rd_addr  in  32  read start address
rd_rdy  out  1  read request accepted this cycle if rd_req
ret_valid  out  1  returned word valid
ret_last  out  1  last word of this read
ret_data  out  32  returned word
wr_req  in  1  cache write request
wr_type  in  3  same encoding as rd_type
wr_addr  in  32  write start address
wr_wstrb  in  4  byte mask (non-line writes only)
wr_data  in  128  line data; word i = wr_data[32i+31:32i]; non-line uses [31:0]
wr_rdy  out  1  write request accepted this cycle if wr_req
arid/araddr/arlen/arsize/arburst/arvalid  out  4/32/8/3/2/1  AXI AR
arready  in  1  AXI AR
rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1  AXI R
rready  out  1  AXI R
awid/awaddr/awlen/awsize/awburst/awvalid  out  4/32/8/3/2/1  AXI AW
awready  in  1  AXI AW
wdata/wstrb/wlast/wvalid  out  32/4/1/1  AXI W
wready  in  1  AXI W
bid/bresp/bvalid  in  4/2/1  AXI B
bready  out  1  AXI B

Behaviour:
Reset values:
- arvalid, rready, awvalid, wvalid, wlast, bready, ret_valid = 0.
- Latched address, type, data and strobe registers = 0.
- rd_rdy = 1 and wr_rdy = 1 (both engines idle).

Read FSM (R_IDLE, R_AR, R_DATA):
- rd_rdy = R_IDLE & ~hazard.
- Hazard: a write is in flight (write FSM not W_IDLE) with latched wr_addr[31:4] == rd_addr[31:4], OR wr_req & wr_rdy in the same cycle with wr_addr[31:4] == rd_addr[31:4].
- rd_rdy may depend combinationally on rd_addr; the cache holds rd_req and rd_addr stable until accepted.
- rd_req & rd_rdy: latch addr and type, go to R_AR.
- R_AR: arvalid = 1 with stable fields.
  - araddr = latched address.
  - arlen = 3 for line, 0 otherwise.
  - arsize = 2 for line, type[1:0] otherwise.
  - arburst = 2'b01.
  - On arvalid & arready: go to R_DATA.
- R_DATA: rready = 1.
  - ret_valid = rvalid, ret_data = rdata, ret_last = rlast, all combinational with zero latency.
  - The cache applies no backpressure on returned data.
  - rvalid & rlast: return to R_IDLE; rd_rdy is 1 in the next cycle.
- rresp and rid are ignored.

Write FSM (W_IDLE, W_AW, W_DATA, W_RESP):
- wr_rdy = (state == W_IDLE), asserted independent of wr_req; the cache requires wr_rdy to be high before it raises wr_req.
- wr_req & wr_rdy: latch addr, type, wstrb and 128-bit data; clear 2-bit beat counter; go to W_AW.
- W_AW: awvalid = 1.
  - awlen, awsize, awburst derived from wr_type exactly as for AR.
  - On awready: go to W_DATA.
- W_DATA: wvalid = 1.
  - wdata = latched word[beat].
  - wstrb = 4'hF for line, latched wr_wstrb otherwise.
  - wlast = (beat == awlen[1:0]).
  - Each wvalid & wready increments beat. No beat is skipped or repeated under wready stalls.
  - Handshake with wlast: go to W_RESP.
- W_RESP: bready = 1; on bvalid go to W_IDLE.
- bresp and bid are ignored.

Concurrency and reset:
- Both engines run concurrently; a read and a write to different lines accepted in the same cycle proceed independently.
- Reset mid-transaction abandons all state immediately. The interconnect and slave are reset together.

Test Plan:
- Line read: rd_req, type 100, addr 0x1C000040; arready after 2 cycles. Require arlen = 3, arsize = 2, arburst = 1. Rdata beats 0xA0..0xA3 appear on ret_data in the same cycles; ret_last only on 0xA3; rd_rdy = 1 the cycle after rlast.
- Line write: addr 0x00001230, wr_data = {W3,W2,W1,W0}. Require awlen = 3, wdata sequence W0, W1, W2, W3, wstrb F, wlast only on W3. wr_rdy stays 0 until the B handshake, then 1.
- Uncached byte write: type 000, wstrb 0100, addr 0xBFAF8002. Require awlen = 0, awsize = 0, one beat with wstrb 0100 and wlast = 1.
- RAW hazard: write to 0x1000 pending with bvalid withheld.
  - rd_req to 0x1008: rd_rdy = 0 and arvalid = 0 until the B handshake.
  - rd_req to 0x2000: accepted immediately.
- W backpressure: wready pattern 1,0,1,0,1,0,1 on a line write. Require exactly 4 beats in order, no duplicates.
- Reset mid read burst after 2 beats: the next cycle has arvalid = 0, rready = 0, ret_valid = 0, rd_rdy = 1.
